// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA,
        ST_RACK,
        ST_STOP
    } i2c_state_e;

    localparam logic I2C_WRITE = 1'b0;
    localparam logic I2C_READ  = 1'b1;

    // Data phase that follows an ACKed address byte.
    function automatic i2c_state_e data_state(input logic rw);
        return (rw == I2C_READ) ? ST_RDATA : ST_WDATA;
    endfunction

endpackage

// File: rtl/i2c_scl_tick.sv
// Bit-slot timer: one slot is 2*HALF_PERIOD clocks, first half SCL low,
// second half SCL released. Strobes mark the first and last clock of a slot.
module i2c_scl_tick #(
    parameter int HALF_PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic low_start,
    output logic high_end,
    output logic high_phase
);

    localparam int SLOT = 2 * HALF_PERIOD;
    localparam int CW   = $clog2(SLOT);
    localparam logic [CW-1:0] LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] HALF = CW'(HALF_PERIOD);

    logic [CW-1:0] cnt;

    // Slot counter; parked at zero while the controller is idle so the
    // first slot after a start request is always full length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                    cnt <= '0;
        else if (!run || cnt == LAST) cnt <= '0;
        else                         cnt <= cnt + CW'(1);
    end

    assign low_start  = run && (cnt == '0);
    assign high_end   = run && (cnt == LAST);
    assign high_phase = (cnt >= HALF);

endmodule

// File: rtl/i2c_master_controller.sv
// Single-master, single-byte I2C controller (7-bit address, write or read).
// SCL is decoded from the FSM state and slot phase; SDA is registered and
// only moves one clock into the SCL-low half, except for START and STOP.
module i2c_master_controller
    import i2c_pkg::*;
#(
    parameter int HALF_PERIOD = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    inout  wire        i2c_scl
);

    i2c_state_e state, state_nxt;

    logic       low_start, high_end, high_phase;
    logic       accept, last_bit, scl_low, sda_low;
    logic       rw_q;
    logic [7:0] data_q, tx_sh, rx_sh;
    logic [2:0] bit_cnt;

    i2c_scl_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
        .clk       (clk),
        .rst       (rst),
        .run       (state != ST_IDLE),
        .low_start (low_start),
        .high_end  (high_end),
        .high_phase(high_phase)
    );

    assign last_bit = (bit_cnt == 3'd7);
    assign ready    = (state == ST_IDLE) && rst;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    // Next-state decode and SCL drive; every slot advances on its last clock.
    always_comb begin
        state_nxt = state;
        scl_low   = 1'b0;
        accept    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable) begin
                    accept    = 1'b1;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                // SCL stays high while SDA falls, then is pulled low.
                scl_low = high_phase;
                if (high_end) state_nxt = ST_ADDR;
            end
            ST_ADDR: begin
                scl_low = !high_phase;
                if (high_end && last_bit) state_nxt = ST_ADDR_ACK;
            end
            ST_ADDR_ACK: begin
                scl_low = !high_phase;
                if (high_end) state_nxt = (i2c_sda == 1'b0) ? data_state(rw_q) : ST_STOP;
            end
            ST_WDATA: begin
                scl_low = !high_phase;
                if (high_end && last_bit) state_nxt = ST_WACK;
            end
            ST_WACK: begin
                scl_low = !high_phase;
                if (high_end) state_nxt = ST_STOP;
            end
            ST_RDATA: begin
                scl_low = !high_phase;
                if (high_end && last_bit) state_nxt = ST_RACK;
            end
            ST_RACK: begin
                scl_low = !high_phase;
                if (high_end) state_nxt = ST_STOP;
            end
            ST_STOP: begin
                scl_low = !high_phase;
                if (high_end) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: request latch, TX/RX shifters, bit counter, SDA drive, read result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rw_q     <= I2C_WRITE;
            data_q   <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            bit_cnt  <= '0;
            sda_low  <= 1'b0;
            data_out <= '0;
        end else begin
            if (accept) begin
                rw_q    <= rw;
                data_q  <= data_in;
                tx_sh   <= {addr, rw};
                bit_cnt <= '0;
            end
            if (low_start) begin
                case (state)
                    ST_START, ST_STOP: sda_low <= 1'b1;
                    ST_ADDR, ST_WDATA: begin
                        sda_low <= ~tx_sh[7];
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                    end
                    // ACK slots from the target and all read slots: released.
                    default: sda_low <= 1'b0;
                endcase
            end
            if (high_end) begin
                case (state)
                    ST_ADDR, ST_WDATA: bit_cnt <= bit_cnt + 3'd1;
                    ST_ADDR_ACK:       tx_sh   <= data_q;
                    ST_RDATA: begin
                        rx_sh   <= {rx_sh[6:0], i2c_sda};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    ST_RACK:           data_out <= rx_sh;
                    // SDA rises while SCL is high: the STOP condition.
                    ST_STOP:           sda_low  <= 1'b0;
                    default: ;
                endcase
            end
        end
    end

    assign i2c_scl = scl_low ? 1'b0 : 1'bz;
    assign i2c_sda = sda_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Directed bench for i2c_master_controller with pull-ups and a behavioural
// one-register target (i2c_slave_controller) at address 7'h2A.
module tb_i2c_master_controller;
    import i2c_pkg::*;

    localparam logic [6:0] TGT = 7'h2A;
    localparam int P_IDLE = 0, P_ADDR = 1, P_AACK = 2, P_WDATA = 3,
                   P_WACK = 4, P_RDATA = 5, P_RACK = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] data_in = '0;
    wire  [7:0] data_out;
    wire        ready;
    wire        i2c_sda;
    wire        i2c_scl;

    int vectors = 0;
    int miscompares = 0;
    int busy, st0, sp0;

    pullup (i2c_sda);
    pullup (i2c_scl);

    i2c_master_controller #(.HALF_PERIOD(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .addr    (addr),
        .data_in (data_in),
        .enable  (enable),
        .rw      (rw),
        .data_out(data_out),
        .ready   (ready),
        .i2c_sda (i2c_sda),
        .i2c_scl (i2c_scl)
    );

    always #5 clk = ~clk;

    // Behavioural target state.
    int         s_phase = P_IDLE;
    int         s_bits = 0;
    int         s_starts = 0;
    int         s_stops = 0;
    logic [7:0] s_sh = '0;
    logic [7:0] s_reg = 8'h00;
    logic       s_drv = 1'b0;
    logic       s_rw = 1'b0;
    logic       s_mack = 1'b0;
    logic       p_sda = 1'b1;
    logic       p_scl = 1'b1;

    assign i2c_sda = s_drv ? 1'b0 : 1'bz;

    // Target: START/STOP on SDA edges with SCL high, samples on SCL rise,
    // drives on SCL fall; reset together with the master.
    always @(i2c_sda or i2c_scl or rst) begin : i2c_slave_controller
        if (!rst) begin
            s_phase = P_IDLE;
            s_drv   = 1'b0;
            s_bits  = 0;
        end else if (i2c_scl === 1'b1 && p_scl === 1'b1 && i2c_sda !== p_sda) begin
            if (i2c_sda === 1'b0) begin
                s_starts++;
                s_phase = P_ADDR;
                s_bits  = 0;
            end else begin
                s_stops++;
                s_phase = P_IDLE;
            end
            s_drv = 1'b0;
        end else if (i2c_scl === 1'b1 && p_scl !== 1'b1) begin
            case (s_phase)
                P_ADDR, P_WDATA: begin
                    s_sh = {s_sh[6:0], i2c_sda};
                    s_bits++;
                end
                P_RDATA: s_bits++;
                P_RACK: begin
                    s_mack  = i2c_sda;
                    s_phase = P_IDLE;
                end
                default: ;
            endcase
        end else if (i2c_scl === 1'b0 && p_scl === 1'b1) begin
            case (s_phase)
                P_ADDR: if (s_bits == 8) begin
                    if (s_sh[7:1] == TGT) begin
                        s_rw    = s_sh[0];
                        s_drv   = 1'b1;
                        s_phase = P_AACK;
                    end else begin
                        s_phase = P_IDLE;
                    end
                end
                P_AACK: begin
                    s_bits = 0;
                    if (s_rw) begin
                        s_phase = P_RDATA;
                        s_drv   = ~s_reg[7];
                    end else begin
                        s_phase = P_WDATA;
                        s_drv   = 1'b0;
                    end
                end
                P_WDATA: if (s_bits == 8) begin
                    s_reg   = s_sh;
                    s_drv   = 1'b1;
                    s_phase = P_WACK;
                end
                P_WACK: begin
                    s_drv   = 1'b0;
                    s_phase = P_IDLE;
                end
                P_RDATA: begin
                    if (s_bits == 8) begin
                        s_drv   = 1'b0;
                        s_phase = P_RACK;
                    end else begin
                        s_drv = ~s_reg[7 - s_bits];
                    end
                end
                default: ;
            endcase
        end
        p_sda = i2c_sda;
        p_scl = i2c_scl;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction: enable held en_len clocks, optionally re-raised at
    // clock tog_at (with addr/data scrambled); returns clocks with ready low.
    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                           input int en_len, input int tog_at, output int nbusy);
        @(negedge clk);
        addr = a; data_in = d; rw = r; enable = 1'b1;
        nbusy = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            enable = ((k < en_len) || (k == tog_at)) ? 1'b1 : 1'b0;
            if (k == tog_at) begin
                addr    = 7'h00;
                data_in = 8'hFF;
            end
            if (ready) break;
            nbusy++;
        end
        enable = 1'b0;
    endtask

    initial begin
        // Reset held for 20 clocks.
        repeat (20) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_scl", 32'(i2c_scl), 32'd1);
        chk("rst_sda", 32'(i2c_sda), 32'd1);
        chk("rst_dout", 32'(data_out), 32'h00);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_pins", 32'({i2c_scl, i2c_sda}), 32'b11);

        // Write 8'hAA to the target with a 5-clock enable.
        st0 = s_starts; sp0 = s_stops;
        run_txn(TGT, 8'hAA, I2C_WRITE, 5, 0, busy);
        chk("wr_busy", 32'(busy), 32'd80);
        chk("wr_reg", 32'(s_reg), 32'hAA);
        chk("wr_stop", 32'(s_stops - sp0), 32'd1);
        repeat (10) @(negedge clk);
        chk("wr_one_txn", 32'(s_starts - st0), 32'd1);
        chk("wr_idle", 32'(ready), 32'd1);

        // Read it back; master must NACK the data byte.
        sp0 = s_stops;
        run_txn(TGT, 8'h00, I2C_READ, 1, 0, busy);
        chk("rd_busy", 32'(busy), 32'd80);
        chk("rd_dout", 32'(data_out), 32'hAA);
        chk("rd_mnack", 32'(s_mack), 32'd1);
        chk("rd_stop", 32'(s_stops - sp0), 32'd1);

        // No target at 7'h55: address NACK, 11 slots.
        st0 = s_starts; sp0 = s_stops;
        run_txn(7'h55, 8'h55, I2C_WRITE, 1, 0, busy);
        chk("nack_busy", 32'(busy), 32'd44);
        chk("nack_dout", 32'(data_out), 32'hAA);
        chk("nack_reg", 32'(s_reg), 32'hAA);
        chk("nack_frame", 32'({s_starts - st0, s_stops - sp0}), 32'({32'd1, 32'd1}));

        // Enable and inputs toggled mid-transfer must be ignored.
        st0 = s_starts;
        run_txn(TGT, 8'h3C, I2C_WRITE, 1, 30, busy);
        chk("tog_busy", 32'(busy), 32'd80);
        chk("tog_reg", 32'(s_reg), 32'h3C);
        repeat (5) @(negedge clk);
        chk("tog_one_txn", 32'(s_starts - st0), 32'd1);

        // Reset asserted during the read data phase.
        @(negedge clk);
        addr = TGT; rw = I2C_READ; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        repeat (44) @(negedge clk);
        chk("mid_busy", 32'(ready), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_rst_pins", 32'({i2c_scl, i2c_sda}), 32'b11);
        chk("mid_rst_ready", 32'(ready), 32'd0);
        chk("mid_rst_dout", 32'(data_out), 32'h00);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(ready), 32'd1);

        // Next transaction after the abort completes normally.
        run_txn(TGT, 8'h00, I2C_READ, 1, 0, busy);
        chk("rd2_busy", 32'(busy), 32'd80);
        chk("rd2_dout", 32'(data_out), 32'h3C);

        // Write 8'h00 then read it back.
        run_txn(TGT, 8'h00, I2C_WRITE, 1, 0, busy);
        chk("wr0_reg", 32'(s_reg), 32'h00);
        run_txn(TGT, 8'hFF, I2C_READ, 1, 0, busy);
        chk("rd0_busy", 32'(busy), 32'd80);
        chk("rd0_dout", 32'(data_out), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
